// File: rtl/sa_array_3x3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sa_array_3x3_pkg
// Brief    : Shared widths and latency for the 3x3 systolic MAC array.
// Revision : 1.0
// ============================================================================
package sa_array_3x3_pkg;

    localparam int DATA_W     = 8;
    localparam int PSUM_W     = 18;
    localparam int N          = 3;
    localparam int PROD_W     = 2 * DATA_W;
    // Edge-to-edge delay from an accepted column to its aligned results.
    localparam int SA_LATENCY = 4;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [PSUM_W-1:0] psum_t;

endpackage
`default_nettype wire

// File: rtl/sa_pe.sv
`default_nettype none
// ============================================================================
// Module   : sa_pe
// Brief    : Weight-stationary PE: weight register, feature pass-through,
//            multiply-accumulate into a registered partial sum.
// Revision : 1.0
// ============================================================================
module sa_pe
    import sa_array_3x3_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_w_we,
    input  logic [DATA_W-1:0] i_w_data,
    input  logic [DATA_W-1:0] i_f,
    input  logic [PSUM_W-1:0] i_p,
    output logic [DATA_W-1:0] o_f,
    output logic [PSUM_W-1:0] o_p
);

    logic [DATA_W-1:0] r_weight;
    logic [DATA_W-1:0] r_f;
    logic [PSUM_W-1:0] r_p;
    logic [PROD_W-1:0] w_prod;

    assign w_prod = PROD_W'(i_f) * PROD_W'(r_weight);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_weight <= '0;
            r_f      <= '0;
            r_p      <= '0;
        end else begin
            if (i_w_we) begin
                r_weight <= i_w_data;
            end
            r_f <= i_f;
            r_p <= i_p + PSUM_W'(w_prod);
        end
    end

    assign o_f = r_f;
    assign o_p = r_p;

endmodule
`default_nettype wire

// File: rtl/sa_array_3x3.sv
`default_nettype none
// ============================================================================
// Module   : sa_array_3x3
// Brief    : 3x3 weight-stationary systolic MAC array with internal input
//            skew, output de-skew, valid pipeline and busy-gated weight load.
// Revision : 1.0
// ============================================================================
module sa_array_3x3
    import sa_array_3x3_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              sa_en,
    input  logic [DATA_W-1:0] feature_1,
    input  logic [DATA_W-1:0] feature_2,
    input  logic [DATA_W-1:0] feature_3,
    input  logic              w_load,
    input  logic [1:0]        w_row,
    input  logic [DATA_W-1:0] weight_1,
    input  logic [DATA_W-1:0] weight_2,
    input  logic [DATA_W-1:0] weight_3,
    output logic [PSUM_W-1:0] psum_1,
    output logic [PSUM_W-1:0] psum_2,
    output logic [PSUM_W-1:0] psum_3,
    output logic              out_valid,
    output logic              busy
);

    localparam int c_VALID_STAGES = SA_LATENCY + 1;

    data_t                     w_feat   [N];
    data_t                     w_weight [N];
    data_t                     w_f      [N][N+1];
    psum_t                     w_p      [N+1][N];
    psum_t                     w_col    [N];
    logic [N-1:0]              w_row_we;
    logic                      w_busy;
    logic [c_VALID_STAGES-1:0] r_valid;

    // Idle cycles inject a zero column so the array free-runs with bubbles.
    assign w_feat[0]   = sa_en ? feature_1 : '0;
    assign w_feat[1]   = sa_en ? feature_2 : '0;
    assign w_feat[2]   = sa_en ? feature_3 : '0;
    assign w_weight[0] = weight_1;
    assign w_weight[1] = weight_2;
    assign w_weight[2] = weight_3;

    assign w_busy = sa_en | (|r_valid);

    generate
        for (genvar r = 0; r < N; r++) begin : g_row
            if (r == 0) begin : g_direct
                assign w_f[r][0] = w_feat[r];
            end else begin : g_skew
                data_t r_skew [r];
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        for (int i = 0; i < r; i++) r_skew[i] <= '0;
                    end else begin
                        r_skew[0] <= w_feat[r];
                        for (int i = 1; i < r; i++) r_skew[i] <= r_skew[i-1];
                    end
                end
                assign w_f[r][0] = r_skew[r-1];
            end

            // Row select 3 matches no row, so it writes nothing.
            assign w_row_we[r] = w_load & ~w_busy & (w_row == 2'(r));

            for (genvar c = 0; c < N; c++) begin : g_col
                sa_pe u_pe (
                    .clk      (clk),
                    .rst      (rst),
                    .i_w_we   (w_row_we[r]),
                    .i_w_data (w_weight[c]),
                    .i_f      (w_f[r][c]),
                    .i_p      (w_p[r][c]),
                    .o_f      (w_f[r][c+1]),
                    .o_p      (w_p[r+1][c])
                );
            end
        end

        for (genvar c = 0; c < N; c++) begin : g_out
            assign w_p[0][c] = '0;
            if (c == N - 1) begin : g_direct
                assign w_col[c] = w_p[N][c];
            end else begin : g_deskew
                localparam int c_DEPTH = N - 1 - c;
                psum_t r_dly [c_DEPTH];
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        for (int i = 0; i < c_DEPTH; i++) r_dly[i] <= '0;
                    end else begin
                        r_dly[0] <= w_p[N][c];
                        for (int i = 1; i < c_DEPTH; i++) r_dly[i] <= r_dly[i-1];
                    end
                end
                assign w_col[c] = r_dly[c_DEPTH-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            r_valid <= {r_valid[c_VALID_STAGES-2:0], sa_en};
        end
    end

    assign psum_1    = w_col[0];
    assign psum_2    = w_col[1];
    assign psum_3    = w_col[2];
    assign out_valid = r_valid[c_VALID_STAGES-1];
    assign busy      = w_busy;

endmodule
`default_nettype wire
